// File: rtl/filter_channel_scheduler.sv
// -----------------------------------------------------------------------------
// filter_channel_scheduler
//   Time-shares one FIR filter between the left and right audio channels.
//   A stereo pair is popped from the codec input FIFO. The left sample is fed
//   to the filter, and its result is collected after FILT_LAT cycles. The
//   right sample is then handled the same way. Finally the filtered pair is
//   pushed to the codec output FIFO. In bypass mode the pair skips the filter
//   and goes straight to the output stage.
//
// Ports
//   CLOCK_50      system clock, rising edge
//   reset         asynchronous active-low reset
//   bypass        route the pair around the filter (sampled at capture)
//   clr_overrun   synchronous clear of the sticky overrun flag
//   read_ready    input FIFO holds a stereo pair
//   left_in       codec left sample
//   right_in      codec right sample
//   read          one-cycle pop strobe to the input FIFO (registered)
//   write_ready   output FIFO can accept a pair
//   write         push strobe to the output FIFO (combinational)
//   left_out      filtered left sample, held until the next capture
//   right_out     filtered right sample, held until the next capture
//   filt_in       sample presented to the filter
//   filt_sel      filter bank select, 0 = left, 1 = right
//   filt_en       one-cycle advance strobe to the filter
//   filt_out      filter result
//   busy          high whenever the sequencer is not idle
//   sample_count  number of pairs written (wrapping)
//   overrun       sticky: a pair was dropped because the output stalled
// -----------------------------------------------------------------------------
module filter_channel_scheduler #(
  parameter int DATA_W    = 24,
  parameter int FILT_LAT  = 2,
  parameter int STALL_MAX = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              bypass,
  input  logic              clr_overrun,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic [DATA_W-1:0] filt_in,
  output logic              filt_sel,
  output logic              filt_en,
  input  logic [DATA_W-1:0] filt_out,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_count,
  output logic              overrun
);

  localparam int WAIT_W  = (FILT_LAT  > 1) ? $clog2(FILT_LAT)  : 1;
  localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(FILT_LAT - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED_L,
    S_WAIT_L,
    S_FEED_R,
    S_WAIT_R,
    S_OUT
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic [STALL_W-1:0]  r_stall;
  logic [DATA_W-1:0]   r_right;
  logic                w_capture;

  assign w_capture = (r_state == S_IDLE) && read_ready;

  // Hold the right sample until its turn at the filter. The left sample needs
  // no separate latch because it is loaded into filt_in at capture.
  always_ff @(posedge CLOCK_50) begin
    if (w_capture) r_right <= right_in;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_stall      <= '0;
      read         <= 1'b0;
      filt_en      <= 1'b0;
      filt_sel     <= 1'b0;
      filt_in      <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_count <= '0;
      overrun      <= 1'b0;
    end else begin
      read    <= 1'b0;
      filt_en <= 1'b0;
      // A drop in OUT below re-sets overrun, so a same-cycle set wins.
      if (clr_overrun) overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read_ready) begin
            read    <= 1'b1;
            r_stall <= '0;
            if (bypass) begin
              left_out  <= left_in;
              right_out <= right_in;
              r_state   <= S_OUT;
            end else begin
              filt_in  <= left_in;
              filt_sel <= 1'b0;
              filt_en  <= 1'b1;
              r_state  <= S_FEED_L;
            end
          end
        end
        S_FEED_L: begin
          r_wait  <= '0;
          r_state <= S_WAIT_L;
        end
        S_WAIT_L: begin
          if (r_wait == WAIT_LAST) begin
            // The filter result for the left sample is valid in this cycle.
            left_out <= filt_out;
            filt_in  <= r_right;
            filt_sel <= 1'b1;
            filt_en  <= 1'b1;
            r_state  <= S_FEED_R;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_FEED_R: begin
          r_wait  <= '0;
          r_state <= S_WAIT_R;
        end
        S_WAIT_R: begin
          if (r_wait == WAIT_LAST) begin
            right_out <= filt_out;
            filt_sel  <= 1'b0;
            r_state   <= S_OUT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_OUT: begin
          if (write_ready) begin
            sample_count <= sample_count + 1'b1;
            r_state      <= S_IDLE;
          end else if (r_stall == STALL_LAST) begin
            // The output FIFO has stalled too long, so drop the pair.
            overrun <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign write = (r_state == S_OUT) && write_ready;
  assign busy  = (r_state != S_IDLE);

endmodule
